// File: rtl/reset_sequencer_pkg.sv
// Shared encodings, default parameters and helpers for the reset sequencer.
// Imported by reset_sequencer and rstseq_wdt.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        RSTSEQ_ST_ASSERT  = 2'd0,
        RSTSEQ_ST_RELEASE = 2'd1,
        RSTSEQ_ST_RUN     = 2'd2
    } rstseq_state_e;

    localparam int RSTSEQ_N_CH_DEF       = 3;
    localparam int RSTSEQ_STRETCH_DEF    = 4;
    localparam int RSTSEQ_STAGGER_DEF    = 2;
    localparam int RSTSEQ_WDT_CYCLES_DEF = 8;

    // Sequence-counter value at which channel ch is released on the following edge.
    function automatic int rstseq_release_at(input int stretch, input int stagger, input int ch);
        return stretch - 1 + ch * stagger;
    endfunction

    function automatic int rstseq_cnt_width(input int n_ch, input int stretch, input int stagger);
        return $clog2(stretch + (n_ch - 1) * stagger + 2);
    endfunction

endpackage

// File: rtl/rstseq_wdt.sv
// Watchdog for the reset sequencer: counts RUN cycles without a heartbeat.
// Only compiled when RSTSEQ_WDT_EN is defined.
`ifdef RSTSEQ_WDT_EN
module rstseq_wdt
    import reset_sequencer_pkg::*;
#(
    parameter int WDT_CYCLES = RSTSEQ_WDT_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic i_run,
    input  logic i_heartbeat,
    output logic o_timeout
);

    localparam int WDT_W = $clog2(WDT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] r_wdt_cnt;

    // Held at zero outside RUN, so every entry to RUN starts a fresh window.
    always_ff @(posedge clock) begin
        if (reset || !i_run || i_heartbeat) begin
            r_wdt_cnt <= '0;
        end else if (r_wdt_cnt != WDT_LAST) begin
            r_wdt_cnt <= r_wdt_cnt + WDT_W'(1);
        end
    end

    assign o_timeout = i_run && !i_heartbeat && (r_wdt_cnt == WDT_LAST);

endmodule
`endif

// File: rtl/reset_sequencer.sv
// Reset stretcher and staggered multi-channel release sequencer with soft reset.
// Optional watchdog re-entry into reset is enabled by defining RSTSEQ_WDT_EN.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int N_CH       = RSTSEQ_N_CH_DEF,
    parameter int STRETCH    = RSTSEQ_STRETCH_DEF,
    parameter int STAGGER    = RSTSEQ_STAGGER_DEF,
    parameter int WDT_CYCLES = RSTSEQ_WDT_CYCLES_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            soft_reset,
    input  logic            heartbeat,
    output logic [N_CH-1:0] rst_out,
    output logic            ready,
    output logic            wdt_fired,
    output logic [1:0]      state
);

    localparam int CNT_W = rstseq_cnt_width(N_CH, STRETCH, STAGGER);

    rstseq_state_e    r_state,   w_state_nxt;
    logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
    logic [N_CH-1:0]  r_rst_out, w_rst_nxt;
    logic             r_ready,   w_ready_nxt;
    logic [N_CH-1:0]  w_rel;
    logic             w_timeout;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_rel[i] = (int'(r_cnt) >= rstseq_release_at(STRETCH, STAGGER, i));
        end
    end

`ifdef RSTSEQ_WDT_EN
    logic w_run;
    logic r_wdt_fired;

    assign w_run = (r_state == RSTSEQ_ST_RUN);

    rstseq_wdt #(
        .WDT_CYCLES (WDT_CYCLES)
    ) u_wdt (
        .clock       (clock),
        .reset       (reset),
        .i_run       (w_run),
        .i_heartbeat (heartbeat),
        .o_timeout   (w_timeout)
    );

    // A simultaneous soft reset takes the restart, so the flag is left alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wdt_fired <= 1'b0;
        end else if (w_timeout && !soft_reset) begin
            r_wdt_fired <= 1'b1;
        end
    end

    assign wdt_fired = r_wdt_fired;
`else
    logic w_unused_heartbeat;
    localparam int unused_wdt_cycles = WDT_CYCLES;

    assign w_unused_heartbeat = heartbeat;
    assign w_timeout          = 1'b0;
    assign wdt_fired          = 1'b0;
`endif

    // NOTE: every next-state signal gets a default first, so no path through this block infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rst_nxt   = r_rst_out;
        w_ready_nxt = r_ready;

        if (soft_reset || w_timeout) begin
            w_state_nxt = RSTSEQ_ST_ASSERT;
            w_cnt_nxt   = '0;
            w_rst_nxt   = '1;
            w_ready_nxt = 1'b0;
        end else begin
            unique case (r_state)
                RSTSEQ_ST_ASSERT: begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_rst_nxt   = r_rst_out & ~w_rel;
                    w_ready_nxt = 1'b0;
                    if (int'(r_cnt) == STRETCH - 1) begin
                        w_state_nxt = RSTSEQ_ST_RELEASE;
                    end
                end
                RSTSEQ_ST_RELEASE: begin
                    // Masking with the current value keeps released channels released.
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    w_rst_nxt = r_rst_out & ~w_rel;
                    if (!r_rst_out[N_CH-1]) begin
                        w_state_nxt = RSTSEQ_ST_RUN;
                        w_ready_nxt = 1'b1;
                    end
                end
                RSTSEQ_ST_RUN: begin
                    w_rst_nxt   = '0;
                    w_ready_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt = RSTSEQ_ST_ASSERT;
                    w_cnt_nxt   = '0;
                    w_rst_nxt   = '1;
                    w_ready_nxt = 1'b0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= RSTSEQ_ST_ASSERT;
            r_cnt     <= '0;
            r_rst_out <= '1;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rst_out <= w_rst_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    assign rst_out = r_rst_out;
    assign ready   = r_ready;
    assign state   = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus random stimulus
// compared every cycle against an edge-count based model of the release timeline.
module tb_reset_sequencer;

    localparam int N_CH       = 3;
    localparam int STRETCH    = 4;
    localparam int STAGGER    = 2;
    localparam int WDT_CYCLES = 8;
`ifdef RSTSEQ_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic            soft_reset;
    logic            heartbeat;
    logic [N_CH-1:0] rst_out;
    logic            ready;
    logic            wdt_fired;
    logic [1:0]      state;

    reset_sequencer #(
        .N_CH       (N_CH),
        .STRETCH    (STRETCH),
        .STAGGER    (STAGGER),
        .WDT_CYCLES (WDT_CYCLES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .heartbeat  (heartbeat),
        .rst_out    (rst_out),
        .ready      (ready),
        .wdt_fired  (wdt_fired),
        .state      (state)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: m_n counts edges, m_start is the edge of the latest (re)start,
    // m_anchor is the edge of the latest heartbeat or RUN entry.
    int m_n      = 0;
    int m_start  = 0;
    int m_anchor = 0;
    bit m_fired  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, m_n);
    endtask

    // Phase from cycles since restart: 0 assert, 1 release, 2 run.
    function automatic int exp_phase(input int t);
        if (t < STRETCH) return 0;
        if (t < STRETCH + (N_CH - 1) * STAGGER + 1) return 1;
        return 2;
    endfunction

    function automatic logic [N_CH-1:0] exp_rst(input int t);
        logic [N_CH-1:0] v;
        for (int i = 0; i < N_CH; i++) v[i] = (t < STRETCH + i * STAGGER);
        return v;
    endfunction

    task automatic model_edge(input bit r, input bit sf, input bit hb);
        bit was_run;
        was_run = (exp_phase(m_n - m_start) == 2);
        m_n++;
        if (r) begin
            m_start = m_n;
            m_fired = 1'b0;
        end else if (sf) begin
            m_start = m_n;
        end else if (WDT_ON && was_run && !hb && (m_n - m_anchor >= WDT_CYCLES)) begin
            m_start = m_n;
            m_fired = 1'b1;
        end else if (was_run && hb) begin
            m_anchor = m_n;
        end
        if (!was_run && exp_phase(m_n - m_start) == 2) m_anchor = m_n;
    endtask

    task automatic step(input bit r, input bit sf, input bit hb);
        int t;
        reset      = r;
        soft_reset = sf;
        heartbeat  = hb;
        @(posedge clock);
        model_edge(r, sf, hb);
        @(negedge clock);
        t = m_n - m_start;
        check("rst_out",   32'(rst_out),   32'(exp_rst(t)));
        check("ready",     32'(ready),     32'(exp_phase(t) == 2));
        check("state",     32'(state),     32'(exp_phase(t)));
        check("wdt_fired", 32'(wdt_fired), 32'(m_fired));
    endtask

`ifdef RSTSEQ_WDT_EN
    // Idle until the next edge would be a watchdog timeout.
    task automatic run_until_due();
        int guard = 0;
        while (!(exp_phase(m_n - m_start) == 2 && (m_n + 1 - m_anchor >= WDT_CYCLES)) && guard < 100) begin
            step(1'b0, 1'b0, 1'b0);
            guard++;
        end
        check("wdt_due_reached", 32'(guard < 100), 32'd1);
    endtask
`endif

    initial begin
        int mode;
        bit r, sf, hb;

        // Power-on
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (12) step(1'b0, 1'b0, 1'b1);

        // Soft reset in RUN, full sequence repeats
        step(1'b0, 1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b0, 1'b1);

        // Soft reset during RELEASE after channel 0 has cleared
        step(1'b0, 1'b1, 1'b1);
        repeat (STRETCH + 1) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b0, 1'b1);

        // Reset mid-RELEASE
        step(1'b0, 1'b1, 1'b1);
        repeat (STRETCH + 1) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        repeat (12) step(1'b0, 1'b0, 1'b1);

        // Periodic heartbeat, then silence
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, (i % 5) == 0);
        repeat (30) step(1'b0, 1'b0, 1'b0);

`ifdef RSTSEQ_WDT_EN
        // Heartbeat coinciding with timeout keeps RUN
        run_until_due();
        step(1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        // Soft reset coinciding with timeout, after clearing the sticky flag
        step(1'b1, 1'b0, 1'b0);
        run_until_due();
        step(1'b0, 1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0, 1'b1);
`endif

        // Long stretch with no heartbeat
        repeat (1000) step(1'b0, 1'b0, 1'b0);

        // Random traffic
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) mode = int'($urandom_range(0, 2));
            r  = ($urandom_range(0, 149) == 0);
            sf = ($urandom_range(0, 39) == 0);
            case (mode)
                0:       hb = 1'($urandom_range(0, 1));
                1:       hb = ($urandom_range(0, 9) == 0);
                default: hb = 1'b0;
            endcase
            step(r, sf, hb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_checks);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset and bring-up sequencer between the board-level clock/reset source and the HeliumCPU `top` hierarchy. It stretches the incoming reset and releases N_CH downstream reset channels in a fixed, staggered order: core, then memory, then peripherals. It also accepts a soft-reset request and can optionally re-enter reset on a watchdog timeout. It replaces the single bare reset pulse previously driven straight into `top`.

## Interface
- N_CH, 3: number of reset output channels, 1..8.
- STRETCH, 4: cycles all channels stay asserted after the reset source drops, ≥1.
- STAGGER, 2: cycles between consecutive channel releases, ≥1.
- WDT_CYCLES, 8: watchdog timeout in cycles, ≥2. Used only when RSTSEQ_WDT_EN is defined.

- clock  in  1  system clock (25 MHz nominal).
- reset  in  1  synchronous, active-high reset.
- soft_reset  in  1  one-cycle request to re-run the reset sequence.
- heartbeat  in  1  watchdog kick from software/core.
- rst_out  out  N_CH  per-channel active-high reset; bit 0 is released first.
- ready  out  1  high when all channels are released (state RUN).
- wdt_fired  out  1  sticky flag: a watchdog reset has occurred.
- state  out  2  current FSM state, for debug.

## Operation
- The FSM has three states: ASSERT (2'd0), RELEASE (2'd1) and RUN (2'd2). State 2'd3 is illegal and must go to ASSERT on the next edge.
- Single counter `cnt`, width $clog2(STRETCH+(N_CH-1)*STAGGER+2). It is cleared on every entry to ASSERT.
- **While reset is high:**
  - state goes to ASSERT, cnt=0, rst_out all ones, ready=0, wdt_fired=0.
  - reset overrides every other input.
- **ASSERT:**
  - cnt increments each cycle.
  - At cnt==STRETCH-1 the FSM enters RELEASE, and rst_out[0] clears on that same edge.
- **RELEASE:**
  - cnt keeps counting.
  - rst_out[i] clears on the edge where the cycle count since ASSERT exit equals i*STAGGER.
  - Once rst_out[N_CH-1] is clear, the next edge enters RUN and sets ready=1.
  - Released channels never re-assert except on a return to ASSERT.
- **RUN:** steady state. ready=1 and rst_out=0.
- **soft_reset:**
  - Sampled in every state.
  - When high, the next edge forces ASSERT, cnt=0 and rst_out all ones.
  - In ASSERT it restarts the stretch.
  - It does not clear wdt_fired.
- **Simultaneous events, priority order:** reset > soft_reset > watchdog timeout > normal sequencing.
- **N_CH=1:** RELEASE lasts a single cycle.

## Timing
- E0 is the first rising edge at which reset is sampled low.
- rst_out[i] is low after edge E0+STRETCH-1+i*STAGGER.
- ready is high after edge E0+STRETCH+(N_CH-1)*STAGGER.
- soft_reset sampled high at edge E causes rst_out all ones after edge E. The full sequence then repeats, using E in place of E0.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
- Macro: RSTSEQ_WDT_EN.
- **Defined:**
  - The watchdog counter runs only in RUN.
  - It is cleared on entry to RUN and on any cycle with heartbeat=1.
  - When it reaches WDT_CYCLES-1 with heartbeat=0, the next edge enters ASSERT and sets wdt_fired=1.
  - wdt_fired is sticky until reset.
  - If heartbeat and timeout occur in the same cycle, heartbeat wins.
  - If soft_reset and timeout occur in the same cycle, soft_reset wins and wdt_fired is unchanged.
- **Undefined:** heartbeat is ignored, wdt_fired is tied to 0, WDT_CYCLES is unused, and no watchdog flops exist.

## Structure
- Shared header/package (`defines.v`): state encodings RSTSEQ_ST_ASSERT/RELEASE/RUN and the default parameter constants.
- Sub-module `rstseq_wdt`:
  - Watchdog counter plus timeout pulse.
  - Instantiated only under RSTSEQ_WDT_EN.
- The `testbench` instantiates reset_sequencer and drives `top` from rst_out[0].

## Test plan
All scenarios use N_CH=3, STRETCH=4, STAGGER=2, WDT_CYCLES=8, with RSTSEQ_WDT_EN defined unless stated.
1. Power-on: reset high for 2 cycles, then low → rst_out=3'b111 until E0+3, then 3'b110 after E0+3, 3'b100 after E0+5, 3'b000 after E0+7, and ready=1 after E0+8.
2. soft_reset pulse in RUN → rst_out=3'b111 and ready=0 on the next edge. The sequence repeats with identical offsets, and wdt_fired stays 0.
3. soft_reset during RELEASE after rst_out[0] has cleared → rst_out returns to 3'b111 and the stretch restarts from cnt=0.
4. heartbeat every 5 cycles in RUN for 100 cycles → no reset. Stopping heartbeat → ASSERT 8 cycles after the last kick, wdt_fired=1, then the normal sequence runs and wdt_fired stays 1.
5. heartbeat and timeout in the same cycle → remains in RUN. soft_reset and timeout in the same cycle → ASSERT with wdt_fired=0.
6. reset asserted mid-RELEASE → all outputs return to their reset values on the next edge. Build without RSTSEQ_WDT_EN → no reset occurs over 1000 cycles with heartbeat=0, and wdt_fired=0.
